// File: rtl/adc_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_packetizer_pkg
// Description : Shared types and constants for the ADC packetizer: framing
//               state encoding, cfg bit positions, status field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_packetizer_pkg;

  // Framing state: IDLE discards samples, RUN frames them, CLOSING waits for
  // one more sample to terminate a packet after enable dropped.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CLOSING = 2'd2
  } state_t;

  // cfg register layout
  localparam int CFG_ENABLE  = 31;
  localparam int CFG_LEN_MSB = 23;
  localparam int LEN_W       = CFG_LEN_MSB + 1;

  // status register layout
  localparam int STAT_OVERFLOW  = 31;
  localparam int STAT_IN_PACKET = 30;
  localparam int STAT_PKT_MSB   = 29;
  localparam int STAT_PKT_LSB   = 16;
  localparam int STAT_DROP_MSB  = 15;
  localparam int STAT_DROP_LSB  = 0;
  localparam int PKT_CNT_W      = STAT_PKT_MSB - STAT_PKT_LSB + 1;
  localparam int DROP_CNT_W     = STAT_DROP_MSB - STAT_DROP_LSB + 1;

  // Assemble the status word from its fields.
  function automatic logic [31:0] pack_status(
    input logic                  overflow,
    input logic                  in_packet,
    input logic [PKT_CNT_W-1:0]  pkt_cnt,
    input logic [DROP_CNT_W-1:0] drop_cnt
  );
    return {overflow, in_packet, pkt_cnt, drop_cnt};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_packetizer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with a registered
//               head. The head register counts toward DEPTH, so exactly
//               DEPTH entries can be held. A push into an empty FIFO is
//               visible on rd_data the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push;
  logic             pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_valid & rd_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push  = wr_en & (~full | pop);

  // Next read pointer, occupancy and head value; a push into a FIFO that is
  // empty after this cycle's pop bypasses the array straight to the head.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);
    head_nxt   = (push && (count == (AW+1)'(pop))) ? wr_data : mem[rd_ptr_nxt];
  end

  // Storage array write port (no reset needed; occupancy guards reads).
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head; reset flushes everything.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        rd_data <= head_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : adc_packetizer
// Description : Frames the free-running ADC sample stream into fixed-length
//               AXI-Stream packets for the S2MM DMA. An FWFT FIFO absorbs DMA
//               stalls; samples arriving while it is full are dropped.
//               Build option ADC_PACKETIZER_DROP_CNT_EN adds the 16-bit
//               saturating drop counter reported in status[15:0].
// Revision    : 1.0 - initial release
// ============================================================================
module adc_packetizer
  import adc_packetizer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [31:0]       cfg,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [31:0]       status
);

  state_t                 state;
  logic [LEN_W-1:0]       beat_cnt;
  logic [LEN_W-1:0]       len_q;
  logic                   enable_q;
  logic [PKT_CNT_W-1:0]   pkt_cnt;
  logic [DROP_CNT_W-1:0]  drop_cnt;
  logic                   overflow;

  logic                   enable;
  logic [LEN_W-1:0]       cfg_len;
  logic                   en_rise;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   wr;
  logic                   wr_last;
  logic                   pkt_inc;
  logic                   drop;
  logic                   in_packet;
  logic                   unused_bits;

  assign enable      = cfg[CFG_ENABLE];
  assign cfg_len     = cfg[CFG_LEN_MSB:0];
  assign en_rise     = enable & ~enable_q;
  assign unused_bits = ^{cfg[30:LEN_W], fifo_empty};

  // Decide whether the current sample is written, dropped or discarded, and
  // whether it terminates a packet (natural length or forced close).
  always_comb begin
    wr      = 1'b0;
    wr_last = 1'b0;
    pkt_inc = 1'b0;
    drop    = 1'b0;
    case (state)
      RUN: begin
        if (enable) begin
          wr      = s_axis_tvalid & ~fifo_full;
          wr_last = (beat_cnt == len_q);
          drop    = s_axis_tvalid & fifo_full;
        end else if (beat_cnt != '0) begin
          wr      = s_axis_tvalid & ~fifo_full;
          wr_last = 1'b1;
          drop    = s_axis_tvalid & fifo_full;
        end
        // enable low on a packet boundary: sample discarded, not a drop
      end
      CLOSING: begin
        wr      = s_axis_tvalid & ~fifo_full;
        wr_last = 1'b1;
        drop    = s_axis_tvalid & fifo_full;
      end
      default: ;
    endcase
    pkt_inc = wr & wr_last;
  end

  // Framing FSM with beat/length tracking, packet count and overflow flag;
  // an enable rising edge restarts the statistics.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      enable_q <= 1'b0;
      pkt_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      enable_q <= enable;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= RUN;
            beat_cnt <= '0;
            len_q    <= cfg_len;
          end
        end
        RUN: begin
          if (enable) begin
            if (wr) begin
              if (wr_last) begin
                beat_cnt <= '0;
                len_q    <= cfg_len;
              end else begin
                beat_cnt <= beat_cnt + LEN_W'(1);
              end
            end
          end else if (beat_cnt == '0) begin
            state <= IDLE;
          end else if (wr) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else begin
            state <= CLOSING;
          end
        end
        CLOSING: begin
          if (wr) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      if (en_rise) begin
        pkt_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        if (pkt_inc) begin
          pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef ADC_PACKETIZER_DROP_CNT_EN
  // Saturating count of samples lost to a full FIFO since the last enable.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt <= '0;
    end else if (en_rise) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`else
  assign drop_cnt = '0;
`endif

  assign in_packet = (state == CLOSING) | ((state == RUN) & (beat_cnt != '0));
  assign status    = pack_status(overflow, in_packet, pkt_cnt, drop_cnt);

  axis_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .wr_data  ({wr_last, s_axis_tdata}),
    .wr_en    (wr),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_data  ({m_axis_tlast, m_axis_tdata}),
    .rd_valid (m_axis_tvalid),
    .rd_ready (m_axis_tready)
  );

endmodule
`default_nettype wire

// File: tb/tb_adc_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_packetizer
// Description : Self-checking bench for adc_packetizer: directed scenarios
//               followed by randomized traffic, checked every cycle against
//               a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_packetizer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_CLOSING = 2;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [31:0]       cfg = '0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [31:0]       status;

  adc_packetizer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg           (cfg),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .status        (status)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];
  int    mode, beat, len, pkt, drop;
  bit    en_prev, ovf;

  task automatic model_reset();
    q.delete();
    mode = M_IDLE; beat = 0; len = 0; pkt = 0; drop = 0;
    en_prev = 1'b0; ovf = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    logic        in_pkt;
    logic [15:0] d16;
    logic [13:0] p14;
    in_pkt = (mode == M_CLOSING) || (mode == M_RUN && beat != 0);
`ifdef ADC_PACKETIZER_DROP_CNT_EN
    d16 = 16'(drop);
`else
    d16 = 16'd0;
`endif
    p14 = 14'(pkt);
    return {ovf, in_pkt, p14, d16};
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_update(input bit v, input logic [31:0] d, input bit rdy);
    bit en, full, pop, wr, last, may_drop;
    int clen, nmode;
    en   = cfg[31];
    clen = int'(cfg[23:0]);
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && rdy;
    wr = 0; last = 0; may_drop = 0; nmode = mode;
    case (mode)
      M_IDLE: if (en) begin nmode = M_RUN; beat = 0; len = clen; end
      M_RUN: begin
        if (en) begin
          may_drop = 1;
          if (v && !full) begin
            wr = 1; last = (beat == len);
            if (last) begin beat = 0; len = clen; pkt++; end
            else beat++;
          end
        end else if (beat == 0) begin
          nmode = M_IDLE;
        end else begin
          may_drop = 1;
          if (v && !full) begin wr = 1; last = 1; pkt++; beat = 0; nmode = M_IDLE; end
          else nmode = M_CLOSING;
        end
      end
      default: begin
        may_drop = 1;
        if (v && !full) begin wr = 1; last = 1; pkt++; beat = 0; nmode = M_IDLE; end
      end
    endcase
    if (may_drop && v && full) begin
      if (drop < 65535) drop++;
      ovf = 1;
    end
    if (en && !en_prev) begin pkt = 0; drop = 0; ovf = 0; end
    en_prev = en;
    mode = nmode;
    if (pop) void'(q.pop_front());
    if (wr) q.push_back('{last: last, data: d});
  endtask

  task automatic check_outputs();
    if (q.size() != 0) begin
      chk("tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("tdata", m_axis_tdata, q[0].data);
      chk("tlast", 32'(m_axis_tlast), 32'(q[0].last));
    end else begin
      chk("tvalid_idle", 32'(m_axis_tvalid), 32'd0);
    end
    chk("status", status, exp_status());
  endtask

  // One clock: check at the falling edge, drive, advance model, wait.
  task automatic step(input bit v, input logic [31:0] d, input bit rdy);
    check_outputs();
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    model_update(v, d, rdy);
    @(negedge aclk);
  endtask

  task automatic apply_reset();
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_status", status, 32'd0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  logic [31:0] exp_drop14;
  int          thr;

  initial begin
    model_reset();
`ifdef ADC_PACKETIZER_DROP_CNT_EN
    exp_drop14 = 32'd14;
`else
    exp_drop14 = 32'd0;
`endif
    repeat (2) @(negedge aclk);
    chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_tlast", 32'(m_axis_tlast), 32'd0);
    chk("reset_tdata", m_axis_tdata, 32'd0);
    chk("reset_status", status, 32'd0);
    aresetn = 1'b1;

    // 1: LEN=3, 12 samples, tready=1
    cfg = {1'b1, 7'd0, 24'd3};
    step(0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 32'(i), 1);
    repeat (4) step(0, 0, 1);
    chk("t1_pkts", 32'(status[29:16]), 32'd3);
    chk("t1_drop", 32'(status[15:0]), 32'd0);

    // 2: tready low for 30 samples -> 16 stored, 14 dropped
    for (int i = 0; i < 30; i++) step(1, 32'(100 + i), 0);
    chk("t2_drop", 32'(status[15:0]), exp_drop14);
    chk("t2_ovf", 32'(status[31]), 32'd1);
    repeat (20) step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'(200 + i), 1);
    repeat (3) step(0, 0, 1);

    // 6 + 3: re-enable clears stats; LEN=7 closed early by enable drop
    cfg = {1'b0, 7'd0, 24'd7};
    step(0, 0, 1);
    cfg[31] = 1'b1;
    step(0, 0, 1);
    chk("t6_ovf", 32'(status[31]), 32'd0);
    chk("t6_drop", 32'(status[15:0]), 32'd0);
    chk("t6_pkts", 32'(status[29:16]), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 32'(300 + i), 1);
    cfg[31] = 1'b0;
    step(0, 0, 1);
    step(1, 32'd303, 1);
    for (int i = 0; i < 3; i++) step(1, 32'(304 + i), 1);
    chk("t3_pkts", 32'(status[29:16]), 32'd1);
    chk("t3_inpkt", 32'(status[30]), 32'd0);

    // 4: LEN=0 then LEN=1 mid-stream
    cfg = {1'b1, 7'd0, 24'd0};
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'(400 + i), 1);
    cfg[23:0] = 24'd1;
    for (int i = 0; i < 6; i++) step(1, 32'(410 + i), 1);
    repeat (3) step(0, 0, 1);

    // 5: reset mid-packet with 5 entries held
    cfg = {1'b1, 7'd0, 24'd7};
    for (int i = 0; i < 5; i++) step(1, 32'(500 + i), 0);
    apply_reset();
    step(0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 32'(600 + i), 1);
    repeat (3) step(0, 0, 1);

    // randomized traffic
    thr = 8;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) thr = $urandom_range(1, 10);
      if ($urandom_range(0, 99) == 0) cfg[31] = ~cfg[31];
      if ($urandom_range(0, 59) == 0) cfg[23:0] = 24'($urandom_range(0, 5));
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < thr);
    end
    cfg[31] = 1'b0;
    repeat (40) step(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
